// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-issue sequencer between the Zhinx instruction stream and the add, mul and div/sqrt units.
// Build option FPU_FUSED_EN: FMADD/FMSUB/FNMADD/FNMSUB run as a multiply followed by an add on unit 0.
module fpu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int UNIT_N         = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              insn_valid,
    output logic              insn_ready,
    input  logic [31:0]       insn,
    input  logic [15:0]       rs1_data,
    input  logic [15:0]       rs2_data,
    input  logic [15:0]       rs3_data,
    input  logic [2:0]        frm,
    output logic [UNIT_N-1:0] eu_start,
    output logic [3:0]        eu_op,
    output logic [2:0]        eu_rm,
    output logic [15:0]       eu_a,
    output logic [15:0]       eu_b,
    input  logic [UNIT_N-1:0] eu_done,
    input  logic [15:0]       eu_result,
    input  logic [4:0]        eu_flags,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [4:0]        resp_rd,
    output logic [31:0]       resp_data,
    output logic [4:0]        resp_flags,
    output logic              resp_illegal,
    output logic              resp_timeout,
    output logic              busy
);
    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;
    localparam logic [1:0] FMT_HALF   = 2'b10;

    localparam logic [4:0] F5_ADD    = 5'b00000;
    localparam logic [4:0] F5_SUB    = 5'b00001;
    localparam logic [4:0] F5_MUL    = 5'b00010;
    localparam logic [4:0] F5_DIV    = 5'b00011;
    localparam logic [4:0] F5_SQRT   = 5'b01011;
    localparam logic [4:0] F5_SGNJ   = 5'b00100;
    localparam logic [4:0] F5_MINMAX = 5'b00101;
    localparam logic [4:0] F5_CMP    = 5'b10100;
    localparam logic [4:0] F5_CLASS  = 5'b11100;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd2;
    localparam logic [3:0] OP_DIV    = 4'd3;
    localparam logic [3:0] OP_SQRT   = 4'd4;
    localparam logic [3:0] OP_SGNJ   = 4'd5;
    localparam logic [3:0] OP_MINMAX = 4'd6;
    localparam logic [3:0] OP_CMP    = 4'd7;
    localparam logic [3:0] OP_CLASS  = 4'd8;

    localparam logic [1:0] RES_SEXT  = 2'd0;
    localparam logic [1:0] RES_BIT   = 2'd1;
    localparam logic [1:0] RES_CLASS = 2'd2;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
`ifdef FPU_FUSED_EN
        S_FUSE_ISSUE,
        S_FUSE_WAIT,
`endif
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [31:0] insn_q;
    logic [15:0] rs1_q, rs2_q;
    logic [2:0]  frm_q;
    logic [31:0] data_q;
    logic [7:0]  cnt_q;
    logic [4:0]  flags_q;
    logic        illegal_q, timeout_q;

    logic [31:0]       dec_word;
    logic [2:0]        dec_frm;
    logic              dec_illegal, dec_fused;
    logic [UNIT_N-1:0] dec_unit, wait_unit;
    logic [3:0]        dec_op;
    logic [1:0]        dec_res;
    logic [2:0]        rm_res;
    logic              accept, waiting, done_hit, to_hit, unused_bits;

    function automatic logic [31:0] fmt_result(input logic [15:0] r, input logic [1:0] kind);
        case (kind)
            RES_BIT:   return {31'b0, r[0]};
            RES_CLASS: return {22'b0, r[9:0]};
            default:   return {{16{r[15]}}, r};
        endcase
    endfunction

    function automatic logic rm_arith_bad(input logic [2:0] rm, input logic [2:0] dyn);
        return (rm == 3'b101) || (rm == 3'b110) || ((rm == 3'b111) && (dyn >= 3'b101));
    endfunction

    // In IDLE the incoming word is decoded so an illegal one goes straight to RESP;
    // afterwards the latched copy drives routing and operand selection.
    assign dec_word = (state == S_IDLE) ? insn : insn_q;
    assign dec_frm  = (state == S_IDLE) ? frm  : frm_q;
    assign rm_res   = (insn_q[14:12] == 3'b111) ? frm_q : insn_q[14:12];

    always_comb begin
        dec_illegal = 1'b0;
        dec_fused   = 1'b0;
        dec_unit    = UNIT_N'(1);
        dec_op      = OP_ADD;
        dec_res     = RES_SEXT;
        case (dec_word[6:0])
            OPC_OP_FP: begin
                case (dec_word[31:27])
                    F5_ADD:    dec_illegal = rm_arith_bad(dec_word[14:12], dec_frm);
                    F5_SUB: begin
                        dec_op      = OP_SUB;
                        dec_illegal = rm_arith_bad(dec_word[14:12], dec_frm);
                    end
                    F5_MUL: begin
                        dec_op      = OP_MUL;
                        dec_unit    = UNIT_N'(2);
                        dec_illegal = rm_arith_bad(dec_word[14:12], dec_frm);
                    end
                    F5_DIV: begin
                        dec_op      = OP_DIV;
                        dec_unit    = UNIT_N'(4);
                        dec_illegal = rm_arith_bad(dec_word[14:12], dec_frm);
                    end
                    F5_SQRT: begin
                        dec_op      = OP_SQRT;
                        dec_unit    = UNIT_N'(4);
                        dec_illegal = rm_arith_bad(dec_word[14:12], dec_frm) || (dec_word[24:20] != 5'd0);
                    end
                    F5_SGNJ: begin
                        dec_op      = OP_SGNJ;
                        dec_illegal = dec_word[14:12] > 3'b010;
                    end
                    F5_MINMAX: begin
                        dec_op      = OP_MINMAX;
                        dec_illegal = dec_word[14:12] > 3'b001;
                    end
                    F5_CMP: begin
                        dec_op      = OP_CMP;
                        dec_res     = RES_BIT;
                        dec_illegal = dec_word[14:12] > 3'b010;
                    end
                    F5_CLASS: begin
                        dec_op      = OP_CLASS;
                        dec_res     = RES_CLASS;
                        dec_illegal = (dec_word[24:20] != 5'd0) || (dec_word[14:12] != 3'b001);
                    end
                    default:   dec_illegal = 1'b1;
                endcase
                if (dec_word[26:25] != FMT_HALF)
                    dec_illegal = 1'b1;
            end
`ifdef FPU_FUSED_EN
            OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
                dec_fused   = 1'b1;
                dec_op      = OP_MUL;
                dec_unit    = UNIT_N'(2);
                dec_illegal = rm_arith_bad(dec_word[14:12], dec_frm) || (dec_word[26:25] != FMT_HALF);
            end
`endif
            default: dec_illegal = 1'b1;
        endcase
    end

`ifdef FPU_FUSED_EN
    logic [15:0] rs3_q;
    logic [3:0]  fuse_op;
    logic [15:0] fuse_a, fuse_b;

    // Second step consumes the product held in data_q[15:0]; opcode bits [3:2] pick the variant.
    always_comb begin
        fuse_op = OP_ADD;
        fuse_a  = data_q[15:0];
        fuse_b  = rs3_q;
        case (insn_q[3:2])
            2'b01:   fuse_op = OP_SUB;
            2'b10:   fuse_a  = data_q[15:0] ^ 16'h8000;
            2'b11: begin
                fuse_a = data_q[15:0] ^ 16'h8000;
                fuse_b = rs3_q ^ 16'h8000;
            end
            default: ;
        endcase
    end

    assign wait_unit   = (state == S_FUSE_WAIT) ? UNIT_N'(1) : dec_unit;
    assign waiting     = (state == S_WAIT) || (state == S_FUSE_WAIT);
    assign unused_bits = ^{dec_word[19:15], dec_word[11:7]};
`else
    assign wait_unit   = dec_unit;
    assign waiting     = (state == S_WAIT);
    assign unused_bits = ^{dec_word[19:15], dec_word[11:7], rs3_data};
`endif

    assign accept   = (state == S_IDLE) && insn_valid;
    assign done_hit = waiting && |(eu_done & wait_unit);
    assign to_hit   = waiting && !done_hit && (cnt_q == TO_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (insn_valid) state_nxt = dec_illegal ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_hit) begin
`ifdef FPU_FUSED_EN
                    state_nxt = dec_fused ? S_FUSE_ISSUE : S_RESP;
`else
                    state_nxt = S_RESP;
`endif
                end else if (to_hit) begin
                    state_nxt = S_RESP;
                end
            end
`ifdef FPU_FUSED_EN
            S_FUSE_ISSUE: state_nxt = S_FUSE_WAIT;
            S_FUSE_WAIT:  if (done_hit || to_hit) state_nxt = S_RESP;
`endif
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        insn_ready   = (state == S_IDLE);
        busy         = (state != S_IDLE);
        eu_start     = '0;
        eu_op        = 4'd0;
        eu_rm        = 3'd0;
        eu_a         = 16'd0;
        eu_b         = 16'd0;
        resp_valid   = 1'b0;
        resp_rd      = 5'd0;
        resp_data    = 32'd0;
        resp_flags   = 5'd0;
        resp_illegal = 1'b0;
        resp_timeout = 1'b0;
        case (state)
            S_ISSUE, S_WAIT: begin
                eu_start = (state == S_ISSUE) ? dec_unit : '0;
                eu_op    = dec_op;
                eu_rm    = rm_res;
                eu_a     = rs1_q;
                eu_b     = rs2_q;
            end
`ifdef FPU_FUSED_EN
            S_FUSE_ISSUE, S_FUSE_WAIT: begin
                eu_start = (state == S_FUSE_ISSUE) ? UNIT_N'(1) : '0;
                eu_op    = fuse_op;
                eu_rm    = rm_res;
                eu_a     = fuse_a;
                eu_b     = fuse_b;
            end
`endif
            S_RESP: begin
                resp_valid   = 1'b1;
                resp_rd      = insn_q[11:7];
                resp_data    = (illegal_q || timeout_q) ? 32'd0 : data_q;
                resp_flags   = flags_q;
                resp_illegal = illegal_q;
                resp_timeout = timeout_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= 8'd0;
            flags_q   <= 5'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                illegal_q <= dec_illegal;
                timeout_q <= 1'b0;
                cnt_q     <= 8'd0;
            end
            if (done_hit) begin
                flags_q <= flags_q | eu_flags;
                cnt_q   <= 8'd0;
            end else if (to_hit) begin
                timeout_q <= 1'b1;
            end else if (waiting) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if ((state == S_RESP) && resp_ready) begin
                flags_q <= 5'd0;
                cnt_q   <= 8'd0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            insn_q <= insn;
            rs1_q  <= rs1_data;
            rs2_q  <= rs2_data;
            frm_q  <= frm;
`ifdef FPU_FUSED_EN
            rs3_q  <= rs3_data;
`endif
        end
        if (done_hit)
            data_q <= fmt_result(eu_result, dec_res);
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Single-issue sequencer between the core's FP instruction stream and the three half-precision execution units: add/misc, multiply, div/sqrt.
- Decodes RV32 Zhinx instruction words and validates fmt/rm/funct fields.
- Resolves dynamic rounding, dispatches operands to one unit, waits for completion, then returns a 32-bit integer-register result with accrued flags.
- One instruction in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in WAIT before the unit is declared hung (1..255).
- UNIT_N, 3, number of execution units (fixed 3; 0=add/misc, 1=mul, 2=div/sqrt).

Ports:
- CLK  in  1  clock; all state on rising edge
- RST  in  1  asynchronous active-high reset
- insn_valid  in  1  instruction offered
- insn_ready  out  1  controller can accept
- insn  in  32  rv32zhinx_insn_t word
- rs1_data, rs2_data, rs3_data  in  16 each  operand halves (rs3 used only by fused ops)
- frm  in  3  dynamic rounding mode CSR
- eu_start  out  3  one-hot one-cycle start pulse per unit
- eu_op  out  4  fpu_operation_t encoding for the started unit
- eu_rm  out  3  resolved rounding mode / sub-op field
- eu_a, eu_b  out  16 each  unit operands
- eu_done  in  3  per-unit completion pulse
- eu_result  in  16  result from the completing unit (shared bus)
- eu_flags  in  5  NV,DZ,OF,UF,NX from the completing unit
- resp_valid  out  1  response offered
- resp_ready  in  1  consumer accepts
- resp_rd  out  5  destination register
- resp_data  out  32  result
- resp_flags  out  5  accrued flags
- resp_illegal  out  1  illegal instruction, no unit started
- resp_timeout  out  1  unit hang detected
- busy  out  1  not in IDLE

Behaviour:
- Reset: state IDLE. All outputs 0 except insn_ready=1. Timeout counter 0. Reset mid-operation abandons the instruction with no response.
- FSM states: IDLE, ISSUE, WAIT, FUSE_ISSUE, FUSE_WAIT, RESP.
- IDLE: insn_ready=1. On insn_valid&insn_ready, latch insn, operands and frm, and decode combinationally from the latched fields in the next state. If illegal go to RESP with resp_illegal=1, resp_data=0, resp_flags=0. Otherwise go to ISSUE.
- Illegal conditions:
  - fmt != FMT_HALF.
  - Unknown opcode or funct5.
  - FMINMAX rm not in {000,001}.
  - FSGNJ rm > 010.
  - FCOMP rm not in {000,001,010}.
  - FSQRT with rs2 != 0.
  - FCLASS with rs2 != 0 or rm != 001.
  - Arithmetic ops (add/sub/mul/div/sqrt/fused): rm in {101,110}, or rm=111 with frm in {101,110,111}.
- Routing:
  - ADD/SUB/MIN/MAX/SGNJ/FEQ/FLT/FLE/CLASS go to unit 0.
  - MUL goes to unit 1.
  - DIV/SQRT go to unit 2.
- Resolved rounding: eu_rm = frm if rm=111, else rm.
- ISSUE: eu_start[sel] high exactly one cycle; eu_op/eu_rm/eu_a/eu_b valid that cycle and held until leaving WAIT. Next state WAIT.
- WAIT:
  - eu_done[sel] sampled high: capture eu_result and OR eu_flags into the flag accumulator, then go to RESP (or FUSE_ISSUE for fused step 1).
  - eu_done on unselected bits is ignored.
  - The counter increments each WAIT cycle; at TIMEOUT_CYCLES go to RESP with resp_timeout=1, resp_data=0.
- Latency: eu_done may arrive earliest the cycle after the start pulse. resp_valid rises the cycle after done is sampled. Minimum accept-to-resp_valid is 3 cycles.
- Result formatting:
  - FEQ/FLT/FLE: zero-extend the 1-bit result.
  - CLASS: zero-extend the 10-bit result.
  - All others: sign-extend bit 15 to 32.
- RESP: resp_* held stable while resp_valid & !resp_ready. On handshake go to IDLE; the accumulator and counter clear.
- Simultaneous events:
  - RST dominates everything.
  - eu_done arriving on the same cycle the timeout is reached counts as completion.
- No new instruction is accepted until the response handshake completes.

Optional Feature:
- Macro FPU_FUSED_EN.
- Defined:
  - OPCODE_FMADD/FMSUB/FNMADD/FNMSUB are sequenced as MUL(rs1,rs2) on unit 1, then FUSE_ISSUE/FUSE_WAIT on unit 0 with product p.
  - MADD: ADD(p, rs3).
  - MSUB: SUB(p, rs3).
  - NMADD: ADD(p^0x8000, rs3^0x8000).
  - NMSUB: ADD(p^0x8000, rs3).
  - Same eu_rm for both steps. Flags are ORed across both steps. The timeout counter restarts per step.
  - Results are double-rounded (not IEEE-fused).
- Undefined: these opcodes decode as illegal. FUSE states are absent.

Test Plan:
- FADD.H rs1=0x3C00, rs2=0x4000, rm=000; unit0 done after 2 cycles with 0x4200, flags 0 -> eu_start=001 one cycle, resp_data=0x00004200, resp_flags=0.
- FMUL.H rm=111, frm=011; unit1 returns 0xC000, flags 00001 -> eu_rm=011, resp_data=0xFFFFC000, resp_flags=00001.
- fmt=FMT_SINGLE, or FDIV.H with rm=101 -> no eu_start, resp_illegal=1, resp_valid 1 cycle after accept.
- FSQRT.H, unit2 never done, TIMEOUT_CYCLES=8 -> resp_timeout=1 after 8 WAIT cycles; resp_ready held low 5 cycles -> outputs stable, insn_ready=0 throughout.
- FPU_FUSED_EN, FNMADD rs1=0x4000, rs2=0x4000, rs3=0x3C00; mul returns 0x4400 -> second start on unit0 with eu_a=0xC400, eu_b=0xBC00; add returns 0xC500 -> resp_data=0xFFFFC500.
- RST asserted during WAIT -> next edge: IDLE, eu_start=0, resp_valid=0, insn_ready=1; a late eu_done is ignored.
